fd_sequencer: RTL

Parametrised address/index sequencer for the FAST corner-detection datapath. On each accepted start it latches a reference pixel address, then issues the centre index followed by every Bresenham-circle index. It echoes each index as a register-file write address after a configurable datapath latency and pulses `readen` once all samples are captured. It sits between the pixel-address generator and the comparison datapath, and supersedes the fixed 16-point, fixed-latency controller with a start/ready handshake and an abort.

---
 rtl/fd_sequencer_if.sv | 28 ++
 rtl/fd_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fd_sequencer_if.sv
// Handshake and index/write bus between the FAST address generator, the sequencer and the
// comparison datapath.
interface fd_sequencer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned IDX_W  = 5
) ();
  logic              start;
  logic [ADDR_W-1:0] refAddr;
  logic              abort;
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] curAddr;
  logic [IDX_W-1:0]  adjNumber;
  logic              adjValid;
  logic [IDX_W-1:0]  regAddr;
  logic              regWe;
  logic              readen;

  modport master (
    output start, refAddr, abort,
    input  ready, busy, curAddr, adjNumber, adjValid, regAddr, regWe, readen
  );

  modport slave (
    input  start, refAddr, abort,
    output ready, busy, curAddr, adjNumber, adjValid, regAddr, regWe, readen
  );
endinterface

// File: rtl/fd_sequencer.sv
// FAST address/index sequencer: issues centre + circle indices, echoes them as register-file
// writes LAT cycles later and pulses readen once every sample has been written.
module fd_sequencer #(
  parameter int unsigned NPTS   = 16,
  parameter int unsigned LAT    = 2,   // legal range 1..8
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned ADDR_W = 15
) (
  input  logic          clock,
  input  logic          nReset,
  fd_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPTS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [IDX_W-1:0]  adj_num_q, adj_num_d;
  logic              adj_valid_q, adj_valid_d;
  logic              readen_q, readen_d;

  // Write pipeline: stage LAT-1 drives regWe/regAddr directly.
  logic [LAT-1:0]    pv_q, pv_d;
  logic [IDX_W-1:0]  pi_q [LAT];
  logic [IDX_W-1:0]  pi_d [LAT];

  logic accept;
  logic flush;
  logic last_write;

  assign accept     = (state_q == StIdle) && bus.start && !bus.abort;
  assign flush      = (state_q != StIdle) && bus.abort;
  assign last_write = pv_q[LAT-1] && (pi_q[LAT-1] == LastIdx);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    adj_num_d   = adj_num_q;
    adj_valid_d = 1'b0;
    readen_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StIssue;
          cur_addr_d  = bus.refAddr;
          adj_num_d   = '0;
          adj_valid_d = 1'b1;
        end
      end
      StIssue: begin
        if (adj_num_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          adj_num_d   = adj_num_q + 1'b1;
          adj_valid_d = 1'b1;
        end
      end
      StDrain: begin
        if (last_write) begin
          state_d  = StDone;
          readen_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything; adjNumber keeps the last index actually issued.
    if (flush) begin
      state_d     = StIdle;
      adj_num_d   = adj_num_q;
      adj_valid_d = 1'b0;
      readen_d    = 1'b0;
    end
  end

  always_comb begin
    pv_d[0] = adj_valid_q;
    pi_d[0] = adj_valid_q ? adj_num_q : pi_q[0];
    for (int i = 1; i < LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pv_q[i-1] ? pi_q[i-1] : pi_q[i];
    end
    // Indices only move with a valid bit, so regAddr holds while regWe is low.
    if (flush) begin
      pv_d = '0;
      for (int i = 0; i < LAT; i++) begin
        pi_d[i] = pi_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      adj_num_q   <= '0;
      adj_valid_q <= 1'b0;
      readen_q    <= 1'b0;
      pv_q        <= '0;
      for (int i = 0; i < LAT; i++) begin
        pi_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      adj_num_q   <= adj_num_d;
      adj_valid_q <= adj_valid_d;
      readen_q    <= readen_d;
      pv_q        <= pv_d;
      for (int i = 0; i < LAT; i++) begin
        pi_q[i] <= pi_d[i];
      end
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.curAddr   = cur_addr_q;
  assign bus.adjNumber = adj_num_q;
  assign bus.adjValid  = adj_valid_q;
  assign bus.regAddr   = pi_q[LAT-1];
  assign bus.regWe     = pv_q[LAT-1];
  assign bus.readen    = readen_q;

endmodule
